wdt_core: RTL and testbench
===========================

WDT_CORE -- requirements
Module: wdt_core

Interface
REQ-001 Parameter RST_PULSE_LEN, default 4: number of cycles cpu_reset_trig stays high per reset event, legal range 1-15.
REQ-002 Parameter KICK_KEY, default 21'h0A5C3: the value that must be written to KICK to reload the counter.
REQ-003 pclk  in  1  block clock; all state changes on its rising edge.
REQ-004 presetn  in  1  reset, asynchronous, active-low.
REQ-005 addr  in  8  register byte address from the APB slave.
REQ-006 wren  in  1  write strobe; a write occurs on every cycle it is high.
REQ-007 rden  in  1  read strobe.
REQ-008 wr_data  in  21  write data.
REQ-009 cpu_forced_reset  in  1  level request for an immediate CPU reset.
REQ-010 rd_data  out  21  read data.
REQ-011 cpu_reset_trig  out  1  registered CPU reset pulse.

Function
REQ-012 The register map SHALL be as follows; all other addresses read 0 and ignore writes.
- 0x00 CTRL, RW: bit0 EN.
- 0x04 LOAD, RW, 21 bits.
- 0x08 COUNT, RO.
- 0x0C KICK, WO, reads 0.
- 0x10 STATUS: bit0 TIMEOUT, bit1 FORCED; each bit is sticky and write-1-to-clear.
REQ-013 rd_data SHALL be combinational from addr while rden=1, 0 otherwise, and unused upper bits SHALL read 0.
REQ-014 When wren and rden are both high, the write SHALL take effect at the clock edge and rd_data SHALL show the pre-write value.
REQ-015 The FSM SHALL have three states: DISABLED, COUNTING and PULSE.
REQ-016 DISABLED->COUNTING: a write with EN=1 SHALL load COUNT from LOAD, using wr_data if LOAD is written in the same cycle.
REQ-017 COUNTING: COUNT SHALL decrement by 1 per tick; a tick is every cycle unless REQ-030 applies.
REQ-018 COUNTING->PULSE: on a tick when COUNT==0; TIMEOUT SHALL be set and COUNT SHALL hold 0.
REQ-019 A KICK write with wr_data==KICK_KEY in COUNTING SHALL load COUNT from LOAD, including when COUNT==0; the kick SHALL win over the timeout in the same cycle.
REQ-020 A KICK write with any other value SHALL be ignored.
REQ-021 A write of EN=0 in COUNTING SHALL move to DISABLED and freeze COUNT.
REQ-022 An EN=0 write in PULSE SHALL clear EN but SHALL NOT shorten the pulse.
REQ-023 cpu_forced_reset=1 in any state except PULSE SHALL enter PULSE on the next edge and set FORCED, regardless of EN.
REQ-024 PULSE: cpu_reset_trig SHALL be high for exactly RST_PULSE_LEN cycles, starting the cycle after entry, timed by a 4-bit pulse counter.
REQ-025 On exit from PULSE, COUNT SHALL reload from LOAD; the next state SHALL be COUNTING if EN=1, else DISABLED.
REQ-026 cpu_forced_reset held high across the end of PULSE SHALL start a new PULSE on the following edge.
REQ-027 LOAD=0 with EN=1 SHALL time out on the first tick.
REQ-028 Register writes SHALL remain functional in every state.

Reset
REQ-029 presetn low SHALL asynchronously clear:
- CTRL, LOAD, COUNT, STATUS and the pulse counter;
- prescaler state (REQ-030);
- the FSM, to DISABLED;
- cpu_reset_trig, to 0.
A reset in the middle of a pulse SHALL truncate the pulse immediately. cpu_reset_trig SHALL NOT reset this block.

Configuration
REQ-030 With WDT_PRESCALER_EN defined:
- register 0x14 PRESC, RW, 8 bits, reset value 0;
- an 8-bit prescale counter produces one tick every PRESC+1 cycles in COUNTING;
- the prescale counter clears on enable, on a valid kick and on exit from PULSE.
Without the macro, 0x14 reads 0 and there is one tick every cycle.

Verification
REQ-031 Timeout:
- stimulus: LOAD=5, CTRL=1, no kicks;
- response: COUNT goes 5,4,3,2,1,0, TIMEOUT=1 and cpu_reset_trig is high for 4 cycles, after which COUNT=5 and the FSM is back in COUNTING.
REQ-032 Kick:
- stimulus: LOAD=10, CTRL=1, KICK=21'h0A5C3 written when COUNT=3, then KICK=21'h00001;
- response: the first kick reloads COUNT to 10, the bad kick leaves COUNT unchanged, and no pulse occurs before the next natural expiry.
REQ-033 Kick versus timeout:
- stimulus: a valid KICK written in the same cycle as the COUNT==0 tick;
- response: COUNT=LOAD, TIMEOUT stays 0 and cpu_reset_trig stays 0.
REQ-034 Forced reset:
- stimulus: cpu_forced_reset pulsed for 1 cycle while DISABLED;
- response: FORCED=1 and cpu_reset_trig is high for 4 cycles; writing STATUS=2'b11 then clears both flags.
REQ-035 Reset mid-pulse:
- stimulus: presetn pulled low on the 2nd cycle of PULSE;
- response: cpu_reset_trig=0 immediately, all registers read 0 and the FSM is in DISABLED.
REQ-036 Prescaler, with WDT_PRESCALER_EN defined:
- stimulus: PRESC=3, LOAD=2;
- response: the pulse starts 12 cycles after enable (3 ticks of 4 cycles).
- without the macro, reading 0x14 returns 0.

Source files
------------

// File: rtl/wdt_core.sv
// rtl/wdt_core.sv - watchdog timer core with register interface and CPU reset pulse
// Optional tick prescaler (register 0x14) is built when WDT_PRESCALER_EN is defined.
module wdt_core #(
  parameter int unsigned RST_PULSE_LEN = 4,
  parameter logic [20:0] KICK_KEY      = 21'h0A5C3
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [7:0]  addr,
  input  logic        wren,
  input  logic        rden,
  input  logic [20:0] wr_data,
  input  logic        cpu_forced_reset,
  output logic [20:0] rd_data,
  output logic        cpu_reset_trig
);

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_LOAD   = 8'h04;
  localparam logic [7:0] ADDR_COUNT  = 8'h08;
  localparam logic [7:0] ADDR_KICK   = 8'h0C;
  localparam logic [7:0] ADDR_STATUS = 8'h10;
  localparam logic [7:0] ADDR_PRESC  = 8'h14;

  localparam logic [3:0] PULSE_LAST = 4'(RST_PULSE_LEN - 1);

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_COUNTING,
    ST_PULSE
  } state_t;

  state_t      state_q, state_d;
  logic        ctrl_en_q;
  logic [20:0] load_q;
  logic [20:0] count_q, count_d;
  logic [3:0]  pulse_cnt_q, pulse_cnt_d;
  logic        st_timeout_q, st_forced_q;
  logic        set_timeout, set_forced;

  logic        wr_ctrl, wr_load, wr_kick, wr_status;
  logic        kick_ok;
  logic        en_next;
  logic [20:0] load_eff;
  logic        tick;

  assign wr_ctrl   = wren && (addr == ADDR_CTRL);
  assign wr_load   = wren && (addr == ADDR_LOAD);
  assign wr_kick   = wren && (addr == ADDR_KICK);
  assign wr_status = wren && (addr == ADDR_STATUS);
  assign kick_ok   = wr_kick && (wr_data == KICK_KEY);
  assign en_next   = wr_ctrl ? wr_data[0] : ctrl_en_q;
  // A LOAD write landing on a reload cycle takes effect immediately
  assign load_eff  = wr_load ? wr_data : load_q;

`ifdef WDT_PRESCALER_EN
  logic       wr_presc;
  logic [7:0] presc_q;
  logic [7:0] presc_cnt_q, presc_cnt_d;

  assign wr_presc = wren && (addr == ADDR_PRESC);
  assign tick     = (presc_cnt_q == presc_q);

  // Held at zero outside COUNTING, so enable and pulse exit restart the prescale period
  always_comb begin
    presc_cnt_d = presc_cnt_q + 8'd1;
    if (state_q != ST_COUNTING || kick_ok || tick) begin
      presc_cnt_d = '0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      presc_q     <= '0;
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      if (wr_presc) begin
        presc_q <= wr_data[7:0];
      end
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pulse_cnt_d = pulse_cnt_q;
    set_timeout = 1'b0;
    set_forced  = 1'b0;
    case (state_q)
      ST_DISABLED: begin
        if (cpu_forced_reset) begin
          state_d     = ST_PULSE;
          pulse_cnt_d = PULSE_LAST;
          set_forced  = 1'b1;
        end else if (wr_ctrl && wr_data[0]) begin
          state_d = ST_COUNTING;
          count_d = load_eff;
        end
      end
      ST_COUNTING: begin
        if (cpu_forced_reset) begin
          state_d     = ST_PULSE;
          pulse_cnt_d = PULSE_LAST;
          set_forced  = 1'b1;
        end else if (wr_ctrl && !wr_data[0]) begin
          state_d = ST_DISABLED;
        end else if (kick_ok) begin
          count_d = load_q;
        end else if (tick) begin
          if (count_q == '0) begin
            state_d     = ST_PULSE;
            pulse_cnt_d = PULSE_LAST;
            set_timeout = 1'b1;
          end else begin
            count_d = count_q - 21'd1;
          end
        end
      end
      ST_PULSE: begin
        if (pulse_cnt_q == '0) begin
          count_d = load_eff;
          state_d = en_next ? ST_COUNTING : ST_DISABLED;
        end else begin
          pulse_cnt_d = pulse_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_DISABLED;
      end
    endcase
  end

  // Output is registered from the next state so it spans exactly the PULSE residency
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q        <= ST_DISABLED;
      count_q        <= '0;
      pulse_cnt_q    <= '0;
      cpu_reset_trig <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      pulse_cnt_q    <= pulse_cnt_d;
      cpu_reset_trig <= (state_d == ST_PULSE);
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctrl_en_q    <= 1'b0;
      load_q       <= '0;
      st_timeout_q <= 1'b0;
      st_forced_q  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en_q <= wr_data[0];
      end
      if (wr_load) begin
        load_q <= wr_data;
      end
      // A new event outranks a simultaneous write-1-to-clear
      if (set_timeout) begin
        st_timeout_q <= 1'b1;
      end else if (wr_status && wr_data[0]) begin
        st_timeout_q <= 1'b0;
      end
      if (set_forced) begin
        st_forced_q <= 1'b1;
      end else if (wr_status && wr_data[1]) begin
        st_forced_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rden) begin
      case (addr)
        ADDR_CTRL:   rd_data = {20'd0, ctrl_en_q};
        ADDR_LOAD:   rd_data = load_q;
        ADDR_COUNT:  rd_data = count_q;
        ADDR_STATUS: rd_data = {19'd0, st_forced_q, st_timeout_q};
`ifdef WDT_PRESCALER_EN
        ADDR_PRESC:  rd_data = {13'd0, presc_q};
`endif
        default:     rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_wdt_core.sv
// tb/tb_wdt_core.sv - directed self-checking bench for wdt_core
module tb_wdt_core;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_LOAD   = 8'h04;
  localparam logic [7:0] A_COUNT  = 8'h08;
  localparam logic [7:0] A_KICK   = 8'h0C;
  localparam logic [7:0] A_STATUS = 8'h10;
  localparam logic [7:0] A_PRESC  = 8'h14;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic [7:0]  addr = '0;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic [20:0] wr_data = '0;
  logic        cpu_forced_reset = 1'b0;
  logic [20:0] rd_data;
  logic        cpu_reset_trig;

  int checks = 0;
  int errors = 0;

  wdt_core dut (
    .pclk             (pclk),
    .presetn          (presetn),
    .addr             (addr),
    .wren             (wren),
    .rden             (rden),
    .wr_data          (wr_data),
    .cpu_forced_reset (cpu_forced_reset),
    .rd_data          (rd_data),
    .cpu_reset_trig   (cpu_reset_trig)
  );

  always #5 pclk = ~pclk;

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [20:0] d);
    addr = a;
    wr_data = d;
    wren = 1'b1;
    @(posedge pclk);
    #1;
    wren = 1'b0;
    addr = '0;
    wr_data = '0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [20:0] v);
    addr = a;
    rden = 1'b1;
    #1;
    v = rd_data;
    rden = 1'b0;
    addr = '0;
  endtask

  task automatic test_reset;
    logic [20:0] v;
    idle(2);
    checks++;
    if (cpu_reset_trig !== 1'b0) begin
      errors++;
      $display("FAIL reset_trig got=%0b exp=0", cpu_reset_trig);
    end
    reg_read(A_COUNT, v);
    checks++;
    if (v !== 21'd0) begin
      errors++;
      $display("FAIL reset_count got=%0h exp=0", v);
    end
    presetn = 1'b1;
    idle(1);
  endtask

  task automatic test_register_map;
    logic [20:0] v;
    reg_write(A_LOAD, 21'h1FFFFF);
    reg_read(A_LOAD, v);
    checks++;
    if (v !== 21'h1FFFFF) begin
      errors++;
      $display("FAIL load_rw got=%0h exp=1fffff", v);
    end
    reg_write(A_CTRL, 21'h1FFFFE);
    reg_read(A_CTRL, v);
    checks++;
    if (v !== 21'd0) begin
      errors++;
      $display("FAIL ctrl_upper got=%0h exp=0", v);
    end
    reg_write(A_KICK, 21'h0A5C3);
    reg_read(A_KICK, v);
    checks++;
    if (v !== 21'd0) begin
      errors++;
      $display("FAIL kick_reads_zero got=%0h exp=0", v);
    end
    reg_write(8'h20, 21'h12345);
    reg_read(8'h20, v);
    checks++;
    if (v !== 21'd0) begin
      errors++;
      $display("FAIL unmapped got=%0h exp=0", v);
    end
    addr = A_LOAD;
    wr_data = 21'h12345;
    wren = 1'b1;
    rden = 1'b1;
    #1;
    checks++;
    if (rd_data !== 21'h1FFFFF) begin
      errors++;
      $display("FAIL rw_same_cycle got=%0h exp=1fffff", rd_data);
    end
    rden = 1'b0;
    #1;
    checks++;
    if (rd_data !== 21'd0) begin
      errors++;
      $display("FAIL rden_low got=%0h exp=0", rd_data);
    end
    @(posedge pclk);
    #1;
    wren = 1'b0;
    reg_read(A_LOAD, v);
    checks++;
    if (v !== 21'h12345) begin
      errors++;
      $display("FAIL rw_same_cycle_written got=%0h exp=12345", v);
    end
  endtask

  task automatic test_timeout;
    logic [20:0] v;
    reg_write(A_LOAD, 21'd5);
    reg_write(A_CTRL, 21'd1);
    reg_read(A_COUNT, v);
    checks++;
    if (v !== 21'd5) begin
      errors++;
      $display("FAIL timeout_start got=%0d exp=5", v);
    end
    for (int i = 4; i >= 0; i--) begin
      idle(1);
      reg_read(A_COUNT, v);
      checks++;
      if (v !== 21'(i) || cpu_reset_trig !== 1'b0) begin
        errors++;
        $display("FAIL timeout_count got=%0d trig=%0b exp=%0d trig=0", v, cpu_reset_trig, i);
      end
    end
    for (int k = 0; k < 4; k++) begin
      idle(1);
      checks++;
      if (cpu_reset_trig !== 1'b1) begin
        errors++;
        $display("FAIL timeout_pulse cycle=%0d got=%0b exp=1", k, cpu_reset_trig);
      end
      if (k == 0) begin
        reg_read(A_STATUS, v);
        checks++;
        if (v !== 21'd1) begin
          errors++;
          $display("FAIL timeout_status got=%0h exp=1", v);
        end
        reg_read(A_COUNT, v);
        checks++;
        if (v !== 21'd0) begin
          errors++;
          $display("FAIL timeout_hold0 got=%0d exp=0", v);
        end
      end
    end
    idle(1);
    reg_read(A_COUNT, v);
    checks++;
    if (cpu_reset_trig !== 1'b0 || v !== 21'd5) begin
      errors++;
      $display("FAIL timeout_exit trig=%0b count=%0d exp trig=0 count=5", cpu_reset_trig, v);
    end
    idle(1);
    reg_read(A_COUNT, v);
    checks++;
    if (v !== 21'd4) begin
      errors++;
      $display("FAIL timeout_recount got=%0d exp=4", v);
    end
    reg_write(A_CTRL, 21'd0);
    idle(2);
    reg_read(A_COUNT, v);
    checks++;
    if (v !== 21'd4) begin
      errors++;
      $display("FAIL disable_freeze got=%0d exp=4", v);
    end
    reg_write(A_STATUS, 21'd1);
    reg_read(A_STATUS, v);
    checks++;
    if (v !== 21'd0) begin
      errors++;
      $display("FAIL status_w1c got=%0h exp=0", v);
    end
  endtask

  task automatic test_kick;
    logic [20:0] v;
    logic seen;
    reg_write(A_LOAD, 21'd10);
    reg_write(A_CTRL, 21'd1);
    idle(7);
    reg_read(A_COUNT, v);
    checks++;
    if (v !== 21'd3) begin
      errors++;
      $display("FAIL kick_pre got=%0d exp=3", v);
    end
    reg_write(A_KICK, 21'h0A5C3);
    reg_read(A_COUNT, v);
    checks++;
    if (v !== 21'd10) begin
      errors++;
      $display("FAIL kick_reload got=%0d exp=10", v);
    end
    reg_write(A_KICK, 21'h00001);
    reg_read(A_COUNT, v);
    checks++;
    if (v !== 21'd9) begin
      errors++;
      $display("FAIL bad_kick got=%0d exp=9", v);
    end
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      idle(1);
      if (cpu_reset_trig !== 1'b0) seen = 1'b1;
    end
    reg_read(A_COUNT, v);
    checks++;
    if (seen !== 1'b0 || v !== 21'd0) begin
      errors++;
      $display("FAIL kick_no_early_pulse seen=%0b count=%0d exp seen=0 count=0", seen, v);
    end
    idle(1);
    checks++;
    if (cpu_reset_trig !== 1'b1) begin
      errors++;
      $display("FAIL kick_natural_expiry got=%0b exp=1", cpu_reset_trig);
    end
    idle(4);
    reg_write(A_CTRL, 21'd0);
    reg_write(A_STATUS, 21'd3);
  endtask

  task automatic test_kick_vs_timeout;
    logic [20:0] v;
    reg_write(A_LOAD, 21'd3);
    reg_write(A_CTRL, 21'd1);
    idle(3);
    reg_read(A_COUNT, v);
    checks++;
    if (v !== 21'd0) begin
      errors++;
      $display("FAIL kvt_at_zero got=%0d exp=0", v);
    end
    reg_write(A_KICK, 21'h0A5C3);
    reg_read(A_COUNT, v);
    checks++;
    if (v !== 21'd3 || cpu_reset_trig !== 1'b0) begin
      errors++;
      $display("FAIL kvt_reload count=%0d trig=%0b exp count=3 trig=0", v, cpu_reset_trig);
    end
    reg_read(A_STATUS, v);
    checks++;
    if (v !== 21'd0) begin
      errors++;
      $display("FAIL kvt_status got=%0h exp=0", v);
    end
    idle(1);
    reg_read(A_COUNT, v);
    checks++;
    if (v !== 21'd2 || cpu_reset_trig !== 1'b0) begin
      errors++;
      $display("FAIL kvt_continue count=%0d trig=%0b exp count=2 trig=0", v, cpu_reset_trig);
    end
    reg_write(A_CTRL, 21'd0);
  endtask

  task automatic test_forced;
    logic [20:0] v;
    cpu_forced_reset = 1'b1;
    @(posedge pclk);
    #1;
    cpu_forced_reset = 1'b0;
    checks++;
    if (cpu_reset_trig !== 1'b1) begin
      errors++;
      $display("FAIL forced_start got=%0b exp=1", cpu_reset_trig);
    end
    reg_read(A_STATUS, v);
    checks++;
    if (v !== 21'd2) begin
      errors++;
      $display("FAIL forced_status got=%0h exp=2", v);
    end
    for (int k = 1; k < 4; k++) begin
      idle(1);
      checks++;
      if (cpu_reset_trig !== 1'b1) begin
        errors++;
        $display("FAIL forced_pulse cycle=%0d got=%0b exp=1", k, cpu_reset_trig);
      end
    end
    idle(1);
    reg_read(A_COUNT, v);
    checks++;
    if (cpu_reset_trig !== 1'b0 || v !== 21'd3) begin
      errors++;
      $display("FAIL forced_exit trig=%0b count=%0d exp trig=0 count=3", cpu_reset_trig, v);
    end
    idle(2);
    reg_read(A_COUNT, v);
    checks++;
    if (v !== 21'd3) begin
      errors++;
      $display("FAIL forced_back_disabled got=%0d exp=3", v);
    end
    reg_write(A_STATUS, 21'd3);
    reg_read(A_STATUS, v);
    checks++;
    if (v !== 21'd0) begin
      errors++;
      $display("FAIL forced_clear got=%0h exp=0", v);
    end
  endtask

  task automatic test_forced_held;
    logic exp_trig [6];
    exp_trig = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    cpu_forced_reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      idle(1);
      checks++;
      if (cpu_reset_trig !== exp_trig[k]) begin
        errors++;
        $display("FAIL forced_held edge=%0d got=%0b exp=%0b", k, cpu_reset_trig, exp_trig[k]);
      end
    end
    cpu_forced_reset = 1'b0;
    idle(4);
    checks++;
    if (cpu_reset_trig !== 1'b0) begin
      errors++;
      $display("FAIL forced_held_end got=%0b exp=0", cpu_reset_trig);
    end
    reg_write(A_STATUS, 21'd3);
  endtask

  task automatic test_prescaler;
    logic [20:0] v;
`ifdef WDT_PRESCALER_EN
    int cyc;
    reg_write(A_PRESC, 21'd3);
    reg_write(A_LOAD, 21'd2);
    reg_write(A_CTRL, 21'd1);
    cyc = 0;
    while (cpu_reset_trig !== 1'b1 && cyc < 40) begin
      idle(1);
      cyc++;
    end
    checks++;
    if (cyc !== 12) begin
      errors++;
      $display("FAIL presc_latency got=%0d exp=12", cyc);
    end
    idle(4);
    reg_write(A_CTRL, 21'd0);
    reg_write(A_STATUS, 21'd3);
    reg_write(A_PRESC, 21'd0);
    reg_read(A_PRESC, v);
    checks++;
    if (v !== 21'd0) begin
      errors++;
      $display("FAIL presc_rw got=%0h exp=0", v);
    end
`else
    reg_write(A_PRESC, 21'h000FF);
    reg_read(A_PRESC, v);
    checks++;
    if (v !== 21'd0) begin
      errors++;
      $display("FAIL presc_absent got=%0h exp=0", v);
    end
`endif
  endtask

  task automatic test_reset_mid_pulse;
    logic [20:0] v;
    logic [20:0] rd [5];
    logic seen;
    reg_write(A_LOAD, 21'd0);
    reg_write(A_CTRL, 21'd1);
    idle(1);
    checks++;
    if (cpu_reset_trig !== 1'b1) begin
      errors++;
      $display("FAIL load0_timeout got=%0b exp=1", cpu_reset_trig);
    end
    idle(1);
    presetn = 1'b0;
    #1;
    checks++;
    if (cpu_reset_trig !== 1'b0) begin
      errors++;
      $display("FAIL mid_pulse_trig got=%0b exp=0", cpu_reset_trig);
    end
    reg_read(A_CTRL, rd[0]);
    reg_read(A_LOAD, rd[1]);
    reg_read(A_COUNT, rd[2]);
    reg_read(A_STATUS, rd[3]);
    reg_read(A_PRESC, rd[4]);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rd[i] !== 21'd0) begin
        errors++;
        $display("FAIL mid_pulse_reg idx=%0d got=%0h exp=0", i, rd[i]);
      end
    end
    idle(1);
    presetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (cpu_reset_trig !== 1'b0) seen = 1'b1;
    end
    reg_read(A_COUNT, v);
    checks++;
    if (seen !== 1'b0 || v !== 21'd0) begin
      errors++;
      $display("FAIL mid_pulse_disabled seen=%0b count=%0d exp seen=0 count=0", seen, v);
    end
  endtask

  initial begin
    test_reset;
    test_register_map;
    test_timeout;
    test_kick;
    test_kick_vs_timeout;
    test_forced;
    test_forced_held;
    test_prescaler;
    test_reset_mid_pulse;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
